// File: rtl/scroll_pkg.sv
// Character codes and seven-segment patterns shared by the scrolling message display.
package scroll_pkg;

  localparam int CHAR_W = 3;

  typedef enum logic [CHAR_W-1:0] {
    H     = 3'd0,
    E     = 3'd1,
    L     = 3'd2,
    O     = 3'd3,
    D     = 3'd4,
    ONE   = 3'd5,
    DASH  = 3'd6,
    BLANK = 3'd7
  } char_e;

  // Active-low segments, bit i drives segment a..g, indexed by character code.
  localparam logic [6:0] SEG_LUT [8] = '{
    7'b0001001,
    7'b0000110,
    7'b1000111,
    7'b1000000,
    7'b0100001,
    7'b1111001,
    7'b0111111,
    7'b1111111
  };

endpackage

// File: rtl/char_to_ssd.sv
// Combinational character-code to active-low seven-segment decoder.
module char_to_ssd
  import scroll_pkg::*;
(
  input  logic [CHAR_W-1:0] char_i,
  output logic [6:0]        seg_o
);

  assign seg_o = SEG_LUT[char_i];

endmodule

// File: rtl/scroll_msg_display.sv
// Scrolls a writable MSG_LEN-character buffer across NUM_DIGITS seven-segment digits,
// one position per TICK_DIV clock cycles, with pause, direction and runtime load.
module scroll_msg_display
  import scroll_pkg::*;
#(
  parameter int TICK_DIV   = 50000000,
  parameter int NUM_DIGITS = 4,
  parameter int MSG_LEN    = 8
) (
  input  logic                         CLOCK_50,
  input  logic                         Resetn,
  input  logic                         en,
  input  logic                         dir,
  input  logic                         wr_en,
  input  logic [$clog2(MSG_LEN)-1:0]   wr_addr,
  input  logic [CHAR_W-1:0]            wr_char,
  output logic [7*NUM_DIGITS-1:0]      hex,
  output logic [$clog2(MSG_LEN)-1:0]   pos,
  output logic                         tick
);

  localparam int AW = $clog2(MSG_LEN);
  localparam int IW = AW + 1;
  localparam int DW = $clog2(TICK_DIV);

  logic [DW-1:0]           div_q, div_d;
  logic [AW-1:0]           pos_q, pos_d;
  logic                    tick_q;
  logic                    step;
  logic [CHAR_W-1:0]       msg_q [MSG_LEN];
  logic [7*NUM_DIGITS-1:0] hex_q, hex_d;

  always_comb begin
    step  = en && (div_q == DW'(TICK_DIV - 1));
    div_d = div_q;
    pos_d = pos_q;
    if (en) begin
      div_d = step ? '0 : div_q + 1'b1;
    end
    if (step) begin
      if (!dir) begin
        pos_d = (pos_q == AW'(MSG_LEN - 1)) ? '0 : pos_q + 1'b1;
      end else begin
        pos_d = (pos_q == '0) ? AW'(MSG_LEN - 1) : pos_q - 1'b1;
      end
    end
  end

  // Digit k shows msg[(pos + NUM_DIGITS-1-k) mod MSG_LEN]; one extra bit keeps the sum exact.
  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
    logic [IW-1:0] sum;
    logic [AW-1:0] idx;
    logic [6:0]    seg;

    assign sum = {1'b0, pos_q} + IW'(NUM_DIGITS - 1 - k);
    assign idx = (sum >= IW'(MSG_LEN)) ? AW'(sum - IW'(MSG_LEN)) : sum[AW-1:0];

    char_to_ssd u_ssd (
      .char_i (msg_q[idx]),
      .seg_o  (seg)
    );

    assign hex_d[7*k +: 7] = seg;
  end

  always_ff @(posedge CLOCK_50 or negedge Resetn) begin
    if (!Resetn) begin
      div_q  <= '0;
      pos_q  <= '0;
      tick_q <= 1'b0;
      hex_q  <= '1;
      for (int i = 0; i < MSG_LEN; i++) begin
        msg_q[i] <= BLANK;
      end
    end else begin
      div_q  <= div_d;
      pos_q  <= pos_d;
      tick_q <= step;
      hex_q  <= hex_d;
      // Out-of-range addresses match no entry and are dropped.
      for (int i = 0; i < MSG_LEN; i++) begin
        if (wr_en && (wr_addr == AW'(i))) begin
          msg_q[i] <= wr_char;
        end
      end
    end
  end

  assign hex  = hex_q;
  assign pos  = pos_q;
  assign tick = tick_q;

endmodule

// File: tb/tb_scroll_msg_display.sv
// Directed bench: a 4-digit/6-char instance for load, scroll, pause and reset,
// plus a 5-digit/5-char instance for non-power-of-2 wrap.
module tb_scroll_msg_display;
  import scroll_pkg::*;

  typedef struct {
    logic        wrEn;
    logic [2:0]  addr;
    logic [2:0]  ch;
    logic [27:0] expHex;
  } loadVec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstN;
  logic        en, dir, wrEn;
  logic [2:0]  wrAddr, wrChar;
  logic [27:0] hexA;
  logic [2:0]  posA;
  logic        tickA;

  logic        enB, dirB, wrEnB;
  logic [2:0]  wrAddrB, wrCharB;
  logic [34:0] hexB;
  logic [2:0]  posB;
  logic        tickB;

  int checkCount = 0;
  int passCount  = 0;
  int gap        = 0;

  logic [2:0] msgA [6];
  logic [2:0] msgB [5];
  loadVec_t   vecs [10];

  scroll_msg_display #(.TICK_DIV(4), .NUM_DIGITS(4), .MSG_LEN(6)) dutA (
    .CLOCK_50 (clk),
    .Resetn   (rstN),
    .en       (en),
    .dir      (dir),
    .wr_en    (wrEn),
    .wr_addr  (wrAddr),
    .wr_char  (wrChar),
    .hex      (hexA),
    .pos      (posA),
    .tick     (tickA)
  );

  scroll_msg_display #(.TICK_DIV(4), .NUM_DIGITS(5), .MSG_LEN(5)) dutB (
    .CLOCK_50 (clk),
    .Resetn   (rstN),
    .en       (enB),
    .dir      (dirB),
    .wr_en    (wrEnB),
    .wr_addr  (wrAddrB),
    .wr_char  (wrCharB),
    .hex      (hexB),
    .pos      (posB),
    .tick     (tickB)
  );

  function automatic logic [6:0] segOf(input logic [2:0] c);
    case (c)
      3'd0:    return 7'b0001001;
      3'd1:    return 7'b0000110;
      3'd2:    return 7'b1000111;
      3'd3:    return 7'b1000000;
      3'd4:    return 7'b0100001;
      3'd5:    return 7'b1111001;
      3'd6:    return 7'b0111111;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [27:0] hex4(input logic [2:0] c3, c2, c1, c0);
    return {segOf(c3), segOf(c2), segOf(c1), segOf(c0)};
  endfunction

  function automatic logic [27:0] dispA(input int p);
    logic [27:0] r;
    r = '1;
    for (int k = 0; k < 4; k++) begin
      r[7*k +: 7] = segOf(msgA[3'((p + 3 - k) % 6)]);
    end
    return r;
  endfunction

  function automatic logic [34:0] dispB(input int p);
    logic [34:0] r;
    r = '1;
    for (int k = 0; k < 5; k++) begin
      r[7*k +: 7] = segOf(msgB[3'((p + 4 - k) % 5)]);
    end
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic applyStimulus(input logic e, d, w, input logic [2:0] a, c);
    en = e; dir = d; wrEn = w; wrAddr = a; wrChar = c;
    @(negedge clk);
  endtask

  task automatic applyStimulusB(input logic e, d, w, input logic [2:0] a, c);
    enB = e; dirB = d; wrEnB = w; wrAddrB = a; wrCharB = c;
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] simulation timed out");
  end

  initial begin
    rstN = 1'b0;
    en = 1'b0; dir = 1'b0; wrEn = 1'b0; wrAddr = 3'd0; wrChar = 3'd0;
    enB = 1'b0; dirB = 1'b0; wrEnB = 1'b0; wrAddrB = 3'd0; wrCharB = 3'd0;
    foreach (msgA[i]) msgA[i] = BLANK;
    foreach (msgB[i]) msgB[i] = BLANK;

    repeat (2) @(negedge clk);
    checkOutput("reset hex", 64'(hexA), 64'(28'hFFFFFFF));
    checkOutput("reset pos", 64'(posA), 64'(0));
    checkOutput("reset tick", 64'(tickA), 64'(0));
    rstN = 1'b1;

    // Load while paused; hex lags the buffer by one cycle.
    vecs[0] = '{1'b1, 3'd0, H,     hex4(BLANK, BLANK, BLANK, BLANK)};
    vecs[1] = '{1'b1, 3'd1, E,     hex4(H, BLANK, BLANK, BLANK)};
    vecs[2] = '{1'b1, 3'd2, L,     hex4(H, E, BLANK, BLANK)};
    vecs[3] = '{1'b1, 3'd3, L,     hex4(H, E, L, BLANK)};
    vecs[4] = '{1'b1, 3'd4, O,     hex4(H, E, L, L)};
    vecs[5] = '{1'b1, 3'd5, BLANK, hex4(H, E, L, L)};
    vecs[6] = '{1'b1, 3'd6, DASH,  hex4(H, E, L, L)};
    vecs[7] = '{1'b1, 3'd7, DASH,  hex4(H, E, L, L)};
    vecs[8] = '{1'b0, 3'd0, H,     hex4(H, E, L, L)};
    vecs[9] = '{1'b0, 3'd0, H,     hex4(H, E, L, L)};
    foreach (vecs[i]) begin
      applyStimulus(1'b0, 1'b0, vecs[i].wrEn, vecs[i].addr, vecs[i].ch);
      checkOutput($sformatf("load hex row %0d", i), 64'(hexA), 64'(vecs[i].expHex));
      checkOutput($sformatf("load pos row %0d", i), 64'(posA), 64'(0));
      checkOutput($sformatf("load tick row %0d", i), 64'(tickA), 64'(0));
    end
    msgA[0] = H; msgA[1] = E; msgA[2] = L; msgA[3] = L; msgA[4] = O; msgA[5] = BLANK;

    // Scroll left through a full wrap.
    for (int n = 1; n <= 24; n++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 3'd0, 3'd0);
      checkOutput($sformatf("left tick n=%0d", n), 64'(tickA), 64'(n % 4 == 0));
      checkOutput($sformatf("left pos n=%0d", n), 64'(posA), 64'((n / 4) % 6));
      checkOutput($sformatf("left hex n=%0d", n), 64'(hexA), 64'(dispA(((n - 1) / 4) % 6)));
      if (n == 17) checkOutput("wrap display at pos 4", 64'(hexA), 64'(hex4(O, BLANK, H, E)));
    end

    // Scroll right from pos 0 wraps to MSG_LEN-1.
    for (int n = 1; n <= 4; n++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 3'd0, 3'd0);
      checkOutput($sformatf("right tick n=%0d", n), 64'(tickA), 64'(n == 4));
      checkOutput($sformatf("right pos n=%0d", n), 64'(posA), 64'((n == 4) ? 5 : 0));
    end

    // Ten paused cycles stretch the step interval from 4 to 14.
    gap = 0;
    for (int n = 1; n <= 30 && gap == 0; n++) begin
      applyStimulus(!(n >= 3 && n <= 12), 1'b1, 1'b0, 3'd0, 3'd0);
      if (tickA) gap = n;
    end
    checkOutput("pause step gap", 64'(gap), 64'(14));
    checkOutput("pause pos after step", 64'(posA), 64'(4));

    // dir only matters on the step cycle.
    for (int n = 1; n <= 4; n++) begin
      applyStimulus(1'b1, (n >= 3), 1'b0, 3'd0, 3'd0);
      checkOutput($sformatf("dir sample tick n=%0d", n), 64'(tickA), 64'(n == 4));
    end
    checkOutput("dir sample pos", 64'(posA), 64'(3));

    // Write to pos+1 in the same cycle as a left step.
    for (int n = 1; n <= 3; n++) applyStimulus(1'b1, 1'b0, 1'b0, 3'd0, 3'd0);
    applyStimulus(1'b1, 1'b0, 1'b1, 3'd4, DASH);
    msgA[4] = DASH;
    checkOutput("simul tick", 64'(tickA), 64'(1));
    checkOutput("simul pos", 64'(posA), 64'(4));
    applyStimulus(1'b1, 1'b0, 1'b0, 3'd0, 3'd0);
    checkOutput("simul digit3", 64'(hexA[27:21]), 64'(segOf(DASH)));
    checkOutput("simul hex", 64'(hexA), 64'(hex4(DASH, BLANK, H, E)));
    checkOutput("simul hex model", 64'(hexA), 64'(dispA(4)));
    for (int n = 1; n <= 3; n++) applyStimulus(1'b1, 1'b0, 1'b0, 3'd0, 3'd0);
    checkOutput("pre-reset tick", 64'(tickA), 64'(1));
    checkOutput("pre-reset pos", 64'(posA), 64'(5));

    // Asynchronous reset mid-scroll, then run with an empty buffer.
    rstN = 1'b0;
    #1;
    checkOutput("midreset hex", 64'(hexA), 64'(28'hFFFFFFF));
    checkOutput("midreset pos", 64'(posA), 64'(0));
    checkOutput("midreset tick", 64'(tickA), 64'(0));
    #1;
    rstN = 1'b1;
    foreach (msgA[i]) msgA[i] = BLANK;
    for (int n = 1; n <= 20; n++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 3'd0, 3'd0);
      checkOutput($sformatf("postreset hex n=%0d", n), 64'(hexA), 64'(28'hFFFFFFF));
      checkOutput($sformatf("postreset pos n=%0d", n), 64'(posA), 64'((n / 4) % 6));
    end

    // Second instance: MSG_LEN = NUM_DIGITS = 5.
    applyStimulusB(1'b0, 1'b0, 1'b1, 3'd0, H);
    applyStimulusB(1'b0, 1'b0, 1'b1, 3'd1, E);
    applyStimulusB(1'b0, 1'b0, 1'b1, 3'd2, L);
    applyStimulusB(1'b0, 1'b0, 1'b1, 3'd3, O);
    applyStimulusB(1'b0, 1'b0, 1'b1, 3'd4, D);
    applyStimulusB(1'b0, 1'b0, 1'b1, 3'd5, DASH);
    applyStimulusB(1'b0, 1'b0, 1'b1, 3'd7, DASH);
    applyStimulusB(1'b0, 1'b0, 1'b0, 3'd0, 3'd0);
    msgB[0] = H; msgB[1] = E; msgB[2] = L; msgB[3] = O; msgB[4] = D;
    checkOutput("B distinct digits", 64'(hexB),
                64'({segOf(H), segOf(E), segOf(L), segOf(O), segOf(D)}));
    checkOutput("B pos idle", 64'(posB), 64'(0));
    for (int n = 1; n <= 20; n++) begin
      applyStimulusB(1'b1, 1'b0, 1'b0, 3'd0, 3'd0);
      checkOutput($sformatf("B tick n=%0d", n), 64'(tickB), 64'(n % 4 == 0));
      checkOutput($sformatf("B pos n=%0d", n), 64'(posB), 64'((n / 4) % 5));
      checkOutput($sformatf("B hex n=%0d", n), 64'(hexB), 64'(dispB(((n - 1) / 4) % 5)));
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/scroll_msg_display.md
Name: scroll_msg_display

Overview:
- Parametrised successor to the fixed 4-digit rotating-word display.
- Holds a writable message buffer of MSG_LEN characters and scrolls it across NUM_DIGITS seven-segment digits, one step per divided-clock tick.
- Adds run/pause control, scroll direction and runtime message load.
- Sits between board clock/switches and the HEX outputs of the top level.

Parameters:
- TICK_DIV, 50000000: CLOCK_50 cycles per scroll step; must be >= 2.
- NUM_DIGITS, 4: number of seven-segment digits driven; 1 <= NUM_DIGITS <= MSG_LEN.
- MSG_LEN, 8: message buffer depth in characters; must be >= 2.
- CHAR_W, 3: character code width; fixed by the package encoding.

Ports:
- CLOCK_50  in  1  system clock; all state on its rising edge.
- Resetn  in  1  asynchronous, active-low reset.
- en  in  1  1 = scroll runs; 0 = pause, with divider and position held.
- dir  in  1  0 = scroll left (pos increments); 1 = scroll right (pos decrements).
- wr_en  in  1  write strobe into message buffer.
- wr_addr  in  clog2(MSG_LEN)  buffer index; values >= MSG_LEN are ignored (no write).
- wr_char  in  CHAR_W  character code to write.
- hex  out  7*NUM_DIGITS  active-low segments; digit k occupies bits [7k+6:7k]; digit 0 is rightmost.
- pos  out  clog2(MSG_LEN)  current scroll position, i.e. the buffer index shown on the leftmost digit.
- tick  out  1  one-cycle pulse in the cycle pos updates.

Behaviour:
- Reset (async assert, sync release):
  - divider = 0, pos = 0, tick = 0.
  - All buffer entries = BLANK.
  - hex = all ones (every segment off).
- Divider:
  - When en = 1, counts 0..TICK_DIV-1 and wraps to 0.
  - Reaching TICK_DIV-1 with en = 1 asserts the internal step. tick is registered and is high in the same cycle pos takes its new value.
  - When en = 0, the divider holds its value and no step occurs. Deasserting en for one cycle therefore delays the next step by exactly one cycle.
- Position update on step:
  - dir = 0: pos = (pos + 1) mod MSG_LEN, so MSG_LEN-1 wraps to 0.
  - dir = 1: pos = (pos - 1) mod MSG_LEN, so 0 wraps to MSG_LEN-1.
  - dir is sampled only on the step cycle. Changing dir between steps has no effect until the next step.
- Digit mapping:
  - Digit k shows buffer[(pos + NUM_DIGITS-1-k) mod MSG_LEN]; the leftmost digit shows buffer[pos].
  - Index arithmetic uses clog2(MSG_LEN)+1 bits with explicit modulo, so it is correct for non-power-of-2 MSG_LEN.
- Output timing:
  - hex is registered and reflects the pos and buffer state of the previous cycle.
  - Latency is 1 cycle from a pos change (tick high) to the new hex, and 1 cycle from a wr_en cycle to the new character on any digit displaying that address.
- Write:
  - Synchronous, one character per cycle, accepted at any time, including while paused.
- Simultaneous step and write in one cycle:
  - Both take effect.
  - The hex value in the following cycle uses the new pos and the new buffer content.
- Character encoding (segment bit i = a..g for i = 0..6, 0 = lit, bits listed g..a):
  - 0 H = 0001001
  - 1 E = 0000110
  - 2 L = 1000111
  - 3 O = 1000000
  - 4 d = 0100001
  - 5 1 = 1111001
  - 6 DASH = 0111111
  - 7 BLANK = 1111111
- Reset mid-operation: immediately returns every state element to its reset value; the message must be reloaded.

Decomposition:
- Shared package scroll_pkg holds:
  - character code constants H, E, L, O, D, ONE, DASH, BLANK;
  - CHAR_W = 3;
  - the 8-entry segment lookup constant.
- One combinational sub-module, char_to_ssd (CHAR_W in, 7 out).
  - Instantiated NUM_DIGITS times via generate; its outputs feed the hex register.
- Top of the block contains divider, pos register, buffer, index math and output registers.

Test Plan (TICK_DIV = 4, NUM_DIGITS = 4, MSG_LEN = 6 unless noted):
- Reset mid-operation: assert Resetn = 0 during a scroll -> immediately hex = all ones, pos = 0, tick = 0; after release and 20 cycles with en = 1 and no writes, hex stays all ones while pos keeps stepping.
- Load and display: write H, E, L, L, O, BLANK to addresses 0..5 with en = 0 -> hex digits 3..0 = H E L L (0001001, 0000110, 1000111, 1000111) one cycle after the last write; pos stays 0.
- Scroll left: then en = 1, dir = 0 -> tick pulses every 4 cycles; pos = 1, 2, 3, 4, 5, 0. At pos = 4, digits show O, BLANK, H, E (wrap). At pos = 5 → 0 the wrap is observed.
- Scroll right and pause:
  - dir = 1 from pos = 0 -> next step gives pos = 5.
  - en = 0 for 10 cycles -> no tick, divider frozen, and the next tick lands exactly 10 cycles later than it would have.
- Simultaneous events:
  - wr_en to address pos+1 in the same cycle as a step with dir = 0 -> next-cycle digit 3 shows the newly written char.
  - wr_addr = 6 -> buffer unchanged.
- Non-power-of-2 and sizing: MSG_LEN = 5, NUM_DIGITS = 5 -> all digits show distinct entries, and pos wraps 4 → 0.
